// File: rtl/medusa_pkg.sv
// rtl/medusa_pkg.sv - shared state encoding and sizing constants for the strip bank sequencer
package medusa_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_PWR_WAIT  = 3'd1,
      ST_STAGGER   = 3'd2,
      ST_LATCH     = 3'd3,
      ST_IDLE      = 3'd4,
      ST_STREAMING = 3'd5,
      ST_FAULT     = 3'd6
   } state_t;

   localparam int DEF_PORTS  = 8;
   localparam int DEF_STRIPS = 32;
   localparam int DROP_W     = 16;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous level inputs
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/strip_frame_scheduler.sv
// rtl/strip_frame_scheduler.sv - cape power-up sequencing and one WS2812 refresh per LCD frame
module strip_frame_scheduler
   import medusa_pkg::*;
#(
   parameter int PORTS          = DEF_PORTS,
   parameter int STRIPS         = DEF_STRIPS,
   parameter int PWRGD_TIMEOUT  = 1000000,
   parameter int STAGGER_CYCLES = 100000,
   parameter int LATCH_CYCLES   = 3000,
   parameter int START_ARM      = 4
) (
   input  logic              led_clk_i,
   input  logic              rst_i,
   input  logic              pwrgd_i,
   input  logic              frame_toggle_i,
   input  logic [STRIPS-1:0] strips_busy_i,
   output logic              pwr_en_o,
   output logic [PORTS-1:0]  port_en_o,
   output logic              strip_start_o,
   output logic [DROP_W-1:0] frames_dropped_o,
   output logic              fault_o,
   output logic [2:0]        state_o
);

   localparam int TIMER_MAX = max3(PWRGD_TIMEOUT, STAGGER_CYCLES * PORTS, LATCH_CYCLES);
   localparam int TIMER_W   = $clog2(TIMER_MAX + STAGGER_CYCLES + 1);

   typedef logic [TIMER_W-1:0] timer_t;

   localparam timer_t PWR_LAST     = timer_t'(PWRGD_TIMEOUT - 1);
   localparam timer_t STAGGER_LAST = timer_t'(STAGGER_CYCLES - 1);
   localparam timer_t STAGGER_STEP = timer_t'(STAGGER_CYCLES);
   localparam timer_t LATCH_LAST   = timer_t'(LATCH_CYCLES - 1);
   localparam timer_t ARM_LAST     = timer_t'(START_ARM - 1);
   localparam timer_t TIMER_SAT    = '1;

   localparam logic [DROP_W-1:0] DROP_MAX = '1;
   localparam logic [PORTS-1:0]  PORT_LSB = PORTS'(1);

   state_t             state, state_next;
   timer_t             timer;
   timer_t             stagger_mark;
   logic [PORTS-1:0]   port_en, port_en_next;
   logic               pending;
   logic [DROP_W-1:0]  drops;
   logic               start, start_next;
   logic               consume, port_set;
   logic               pwrgd_s, tog_s, tog_d;
   logic               frame_ev;
   logic               all_idle;

   sync_2ff #(.WIDTH(1)) u_sync_pwrgd (
      .clk (led_clk_i),
      .rst (rst_i),
      .d   (pwrgd_i),
      .q   (pwrgd_s)
   );

   sync_2ff #(.WIDTH(1)) u_sync_frame (
      .clk (led_clk_i),
      .rst (rst_i),
      .d   (frame_toggle_i),
      .q   (tog_s)
   );

   assign frame_ev     = tog_s ^ tog_d;
   assign all_idle     = ~|strips_busy_i;
   assign port_en_next = (port_en << 1) | PORT_LSB;

   always_ff @(posedge led_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_OFF;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      start_next = 1'b0;
      consume    = 1'b0;
      port_set   = 1'b0;
      case (state)
         ST_OFF: begin
            state_next = ST_PWR_WAIT;
         end
         ST_PWR_WAIT: begin
            if (pwrgd_s) begin
               state_next = ST_STAGGER;
            end else if (timer == PWR_LAST) begin
               state_next = ST_FAULT;
            end
         end
         ST_STAGGER: begin
            if (!pwrgd_s) begin
               state_next = ST_FAULT;
            end else if (timer == stagger_mark) begin
               port_set = 1'b1;
               if (port_en_next[PORTS-1]) begin
                  state_next = ST_LATCH;
               end
            end
         end
         ST_LATCH: begin
            if (!pwrgd_s) begin
               state_next = ST_FAULT;
            end else if (timer == LATCH_LAST) begin
               state_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (!pwrgd_s) begin
               state_next = ST_FAULT;
            end else if ((pending || frame_ev) && all_idle) begin
               start_next = 1'b1;
               consume    = 1'b1;
               state_next = ST_STREAMING;
            end
         end
         ST_STREAMING: begin
            // Busy is ignored until the strips have had time to raise it.
            if (!pwrgd_s) begin
               state_next = ST_FAULT;
            end else if ((timer >= ARM_LAST) && all_idle) begin
               state_next = ST_LATCH;
            end
         end
         ST_FAULT: begin
            state_next = ST_FAULT;
         end
         default: begin
            state_next = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge led_clk_i or posedge rst_i) begin
      if (rst_i) begin
         timer        <= '0;
         stagger_mark <= '0;
         port_en      <= '0;
         pending      <= 1'b0;
         drops        <= '0;
         start        <= 1'b0;
         tog_d        <= 1'b0;
      end else begin
         tog_d <= tog_s;
         start <= start_next;

         if (state_next != state) begin
            timer <= '0;
         end else if (timer != TIMER_SAT) begin
            timer <= timer + 1'b1;
         end

         if (state == ST_PWR_WAIT) begin
            stagger_mark <= STAGGER_LAST;
         end else if (port_set) begin
            stagger_mark <= stagger_mark + STAGGER_STEP;
         end

         if (state_next == ST_FAULT) begin
            port_en <= '0;
            pending <= 1'b0;
         end else begin
            if (port_set) begin
               port_en <= port_en_next;
            end
            // A start in IDLE swallows any event arriving in the same cycle.
            if (consume) begin
               pending <= 1'b0;
            end else if (frame_ev) begin
               if (!pending) begin
                  pending <= 1'b1;
               end else if (drops != DROP_MAX) begin
                  drops <= drops + 1'b1;
               end
            end
         end
      end
   end

   assign pwr_en_o         = (state != ST_OFF) && (state != ST_FAULT);
   assign fault_o          = (state == ST_FAULT);
   assign port_en_o        = port_en;
   assign strip_start_o    = start;
   assign frames_dropped_o = drops;
   assign state_o          = state;

endmodule

// File: tb/tb_strip_frame_scheduler.sv
// tb/tb_strip_frame_scheduler.sv - directed bench for strip_frame_scheduler
module tb_strip_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pwrgd = 1'b0;
   logic        frame_tog = 1'b0;
   logic [31:0] busy = '0;
   logic        pwr_en;
   logic [7:0]  port_en;
   logic        start;
   logic [15:0] drops;
   logic        fault;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_start = 0;
   int s0;
   int t0;

   always #5 clk = ~clk;

   always @(posedge clk) if (start === 1'b1) n_start <= n_start + 1;

   strip_frame_scheduler #(
      .PORTS          (8),
      .STRIPS         (32),
      .PWRGD_TIMEOUT  (50),
      .STAGGER_CYCLES (10),
      .LATCH_CYCLES   (20),
      .START_ARM      (4)
   ) dut (
      .led_clk_i        (clk),
      .rst_i            (rst),
      .pwrgd_i          (pwrgd),
      .frame_toggle_i   (frame_tog),
      .strips_busy_i    (busy),
      .pwr_en_o         (pwr_en),
      .port_en_o        (port_en),
      .strip_start_o    (start),
      .frames_dropped_o (drops),
      .fault_o          (fault),
      .state_o          (state)
   );

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic check_all_zero(input string tag);
      expect_eq({tag, "_state"}, 32'(state), 32'd0);
      expect_eq({tag, "_pwr_en"}, 32'(pwr_en), 32'd0);
      expect_eq({tag, "_port_en"}, 32'(port_en), 32'd0);
      expect_eq({tag, "_start"}, 32'(start), 32'd0);
      expect_eq({tag, "_fault"}, 32'(fault), 32'd0);
      expect_eq({tag, "_drops"}, 32'(drops), 32'd0);
   endtask

   task automatic release_reset();
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check_all_zero("reset");

      // Power-up: pwrgd raised before edge 5 -> synced at 6 -> STAGGER entered at 7
      release_reset();
      tick();
      expect_eq("pu_pwr_en_c1", 32'(pwr_en), 32'd1);
      expect_eq("pu_state_c1", 32'(state), 32'd1);
      run_to(4);
      pwrgd = 1'b1;
      run_to(6);
      expect_eq("pu_state_c6", 32'(state), 32'd1);
      run_to(7);
      expect_eq("pu_state_c7", 32'(state), 32'd2);
      for (int k = 0; k < 8; k++) begin
         run_to(7 + 10 * (k + 1) - 1);
         expect_eq("pu_port_before", 32'(port_en), (32'd1 << k) - 32'd1);
         run_to(7 + 10 * (k + 1));
         expect_eq("pu_port_step", 32'(port_en), (32'd1 << (k + 1)) - 32'd1);
      end
      expect_eq("pu_state_latch", 32'(state), 32'd3);
      run_to(106);
      expect_eq("pu_state_c106", 32'(state), 32'd3);
      run_to(107);
      expect_eq("pu_state_idle", 32'(state), 32'd4);
      expect_eq("pu_start_idle", 32'(start), 32'd0);

      // Refresh: one toggle, busy held for 100 cycles
      t0 = cyc;
      s0 = n_start;
      frame_tog = ~frame_tog;
      run_to(t0 + 2);
      expect_eq("rf_start_t2", 32'(start), 32'd0);
      run_to(t0 + 3);
      expect_eq("rf_start_t3", 32'(start), 32'd1);
      expect_eq("rf_state_t3", 32'(state), 32'd5);
      busy = 32'h0000_8001;
      run_to(t0 + 4);
      expect_eq("rf_start_t4", 32'(start), 32'd0);
      run_to(t0 + 103);
      busy = '0;
      expect_eq("rf_state_busy", 32'(state), 32'd5);
      run_to(t0 + 104);
      expect_eq("rf_state_latch", 32'(state), 32'd3);
      run_to(t0 + 123);
      expect_eq("rf_state_latch_end", 32'(state), 32'd3);
      run_to(t0 + 124);
      expect_eq("rf_state_idle", 32'(state), 32'd4);
      expect_eq("rf_n_start", 32'(n_start - s0), 32'd1);
      expect_eq("rf_drops", 32'(drops), 32'd0);

      // Drop: start toggle, then two more toggles while streaming
      t0 = cyc;
      s0 = n_start;
      frame_tog = ~frame_tog;
      run_to(t0 + 3);
      expect_eq("dr_start_t3", 32'(start), 32'd1);
      busy = '1;
      run_to(t0 + 10);
      frame_tog = ~frame_tog;
      run_to(t0 + 20);
      frame_tog = ~frame_tog;
      run_to(t0 + 30);
      expect_eq("dr_drops", 32'(drops), 32'd1);
      run_to(t0 + 40);
      busy = '0;
      run_to(t0 + 41);
      expect_eq("dr_state_latch", 32'(state), 32'd3);
      run_to(t0 + 61);
      expect_eq("dr_state_idle", 32'(state), 32'd4);
      expect_eq("dr_start_idle", 32'(start), 32'd0);
      run_to(t0 + 62);
      expect_eq("dr_start_pending", 32'(start), 32'd1);
      expect_eq("dr_state_stream", 32'(state), 32'd5);
      run_to(t0 + 66);
      expect_eq("dr_state_latch2", 32'(state), 32'd3);
      run_to(t0 + 86);
      expect_eq("dr_state_idle2", 32'(state), 32'd4);
      run_to(t0 + 90);
      expect_eq("dr_n_start", 32'(n_start - s0), 32'd2);
      expect_eq("dr_drops_end", 32'(drops), 32'd1);

      // Power loss during STREAMING
      t0 = cyc;
      s0 = n_start;
      frame_tog = ~frame_tog;
      run_to(t0 + 3);
      busy = '1;
      run_to(t0 + 10);
      pwrgd = 1'b0;
      run_to(t0 + 12);
      expect_eq("pl_state_t12", 32'(state), 32'd5);
      run_to(t0 + 13);
      expect_eq("pl_state_fault", 32'(state), 32'd6);
      expect_eq("pl_fault", 32'(fault), 32'd1);
      expect_eq("pl_pwr_en", 32'(pwr_en), 32'd0);
      expect_eq("pl_port_en", 32'(port_en), 32'd0);
      busy = '0;
      run_to(t0 + 20);
      frame_tog = ~frame_tog;
      run_to(t0 + 30);
      frame_tog = ~frame_tog;
      run_to(t0 + 40);
      expect_eq("pl_drops", 32'(drops), 32'd1);
      expect_eq("pl_n_start", 32'(n_start - s0), 32'd1);
      expect_eq("pl_state_hold", 32'(state), 32'd6);
      expect_eq("pl_start", 32'(start), 32'd0);

      // Timeout: pwrgd never arrives
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("to_rst");
      release_reset();
      run_to(50);
      expect_eq("to_state_c50", 32'(state), 32'd1);
      expect_eq("to_pwr_en_c50", 32'(pwr_en), 32'd1);
      run_to(51);
      expect_eq("to_state_fault", 32'(state), 32'd6);
      expect_eq("to_fault", 32'(fault), 32'd1);
      expect_eq("to_pwr_en", 32'(pwr_en), 32'd0);
      expect_eq("to_port_en", 32'(port_en), 32'd0);

      // Async reset mid-STAGGER, then full sequence again
      #3;
      rst = 1'b1;
      #1;
      pwrgd = 1'b1;
      release_reset();
      run_to(33);
      expect_eq("ar_port_07", 32'(port_en), 32'h07);
      expect_eq("ar_state_stag", 32'(state), 32'd2);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("ar_rst");
      tick();
      check_all_zero("ar_rst_clk");
      release_reset();
      run_to(1);
      expect_eq("ar_pwr_en_c1", 32'(pwr_en), 32'd1);
      run_to(13);
      expect_eq("ar_port_01", 32'(port_en), 32'h01);
      run_to(83);
      expect_eq("ar_port_ff", 32'(port_en), 32'hFF);
      expect_eq("ar_state_latch", 32'(state), 32'd3);
      run_to(103);
      expect_eq("ar_state_idle", 32'(state), 32'd4);
      expect_eq("ar_drops", 32'(drops), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
